// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Read misses refill a whole line one word at a time; every write goes to memory.
module dcache_dm #(
    parameter int unsigned WORD_SIZE   = 16,
    parameter int unsigned INDEX_BITS  = 2,
    parameter int unsigned OFFSET_BITS = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cpu_readM,
    input  logic                 cpu_writeM,
    input  logic [WORD_SIZE-1:0] cpu_address,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    output logic                 cpu_ready,
    output logic                 d_readM,
    output logic                 d_writeM,
    output logic [WORD_SIZE-1:0] d_address,
    inout  wire  [WORD_SIZE-1:0] d_data,
    input  logic                 d_ready,
    output logic [15:0]          hit_count,
    output logic [15:0]          miss_count
);

    localparam int unsigned TagBits = WORD_SIZE - INDEX_BITS - OFFSET_BITS;
    localparam int unsigned Lines   = 1 << INDEX_BITS;
    localparam int unsigned Words   = 1 << OFFSET_BITS;

    typedef enum logic [1:0] {StIdle, StFill, StWrite} state_e;

    state_e                 state_q, state_d;
    logic [Lines-1:0]       valid_q;
    logic [TagBits-1:0]     tag_q  [Lines];
    logic [WORD_SIZE-1:0]   data_q [Lines][Words];
    logic [OFFSET_BITS-1:0] word_q;
    logic                   issued_q;
    logic [15:0]            hit_count_q, miss_count_q;

    logic [INDEX_BITS-1:0]  index;
    logic [OFFSET_BITS-1:0] offset;
    logic [TagBits-1:0]     tag;
    logic                   hit, read_hit, read_miss, last_word, fill_capture;
    logic [OFFSET_BITS-1:0] fill_word;

    assign index  = cpu_address[OFFSET_BITS +: INDEX_BITS];
    assign offset = cpu_address[OFFSET_BITS-1:0];
    assign tag    = cpu_address[WORD_SIZE-1 -: TagBits];
    assign hit    = valid_q[index] && (tag_q[index] == tag);

    assign read_hit  = (state_q == StIdle) && cpu_readM && !cpu_writeM && hit;
    assign read_miss = (state_q == StIdle) && cpu_readM && !cpu_writeM && !hit;

    // issued_q marks that a fill read is in flight, so d_ready=1 means data is on the bus.
    assign last_word    = &word_q;
    assign fill_capture = (state_q == StFill) && issued_q && d_ready;
    // On a capture edge the next word's read is accepted too; the final one re-reads word 3.
    assign fill_word    = (fill_capture && !last_word) ? word_q + OFFSET_BITS'(1) : word_q;

    assign cpu_rdata  = data_q[index][offset];
    assign d_data     = d_writeM ? cpu_wdata : {WORD_SIZE{1'bz}};
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cpu_writeM) begin
                    state_d = StWrite;
                end else if (cpu_readM && !hit) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                if (fill_capture && last_word) state_d = StIdle;
            end
            StWrite: begin
                if (d_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cpu_ready = 1'b0;
        d_readM   = 1'b0;
        d_writeM  = 1'b0;
        d_address = '0;
        unique case (state_q)
            StIdle: begin
                cpu_ready = cpu_writeM ? 1'b0 : (cpu_readM ? hit : 1'b1);
            end
            StFill: begin
                d_readM   = 1'b1;
                d_address = {tag, index, fill_word};
            end
            StWrite: begin
                d_writeM  = 1'b1;
                d_address = cpu_address;
                cpu_ready = d_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q      <= '0;
            word_q       <= '0;
            issued_q     <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (read_hit && hit_count_q != 16'hffff) hit_count_q <= hit_count_q + 16'd1;
            if (read_miss) begin
                if (miss_count_q != 16'hffff) miss_count_q <= miss_count_q + 16'd1;
                valid_q[index] <= 1'b0;
                word_q         <= '0;
                issued_q       <= 1'b0;
            end
            if (state_q == StFill && d_ready) begin
                issued_q <= 1'b1;
                if (issued_q) begin
                    word_q <= word_q + OFFSET_BITS'(1);
                    if (last_word) valid_q[index] <= 1'b1;
                end
            end
        end
    end

    // Line storage needs no reset; valid_q alone decides whether it is used.
    always_ff @(posedge clk) begin
        if (fill_capture) data_q[index][word_q] <= d_data;
        if (state_q == StWrite && d_ready && hit) data_q[index][offset] <= cpu_wdata;
        if (read_miss) begin
            tag_q[index] <= '0;
        end else if (fill_capture && last_word) begin
            tag_q[index] <= tag;
        end
    end

endmodule

// File: tb/tb_dcache_dm.sv
// Bench for dcache_dm: 2-cycle memory model, directed sequences and a combinational
// lookup vector table.
module tb_dcache_dm;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_readM = 1'b0;
    logic        cpu_writeM = 1'b0;
    logic [15:0] cpu_address = '0;
    logic [15:0] cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        d_readM;
    logic        d_writeM;
    logic [15:0] d_address;
    wire  [15:0] d_data;
    logic        d_ready;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_t0 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dcache_dm dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_readM  (cpu_readM),
        .cpu_writeM (cpu_writeM),
        .cpu_address(cpu_address),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .d_readM    (d_readM),
        .d_writeM   (d_writeM),
        .d_address  (d_address),
        .d_data     (d_data),
        .d_ready    (d_ready),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    // Memory model: default content is word==address except 0x0002, which holds 0xffff.
    logic [15:0]  wmem [256];
    logic [255:0] wmask = '0;
    logic [1:0]   busy = 2'd0;
    logic         drv = 1'b0;
    logic         prd = 1'b0;
    logic [15:0]  paddr = '0;
    logic [15:0]  rd_log[$];
    int           rd_cyc[$];
    logic [15:0]  wr_log[$];
    int           wr_cyc[$];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (wmask[a[7:0]]) return wmem[a[7:0]];
        return (a == 16'h0002) ? 16'hffff : a;
    endfunction

    assign d_ready = (busy == 2'd0);
    assign d_data  = (drv && d_readM) ? mem_word(paddr) : 16'hzzzz;

    always @(posedge clk) begin
        if (d_ready && (d_readM || d_writeM)) begin
            busy  <= 2'd2;
            drv   <= 1'b0;
            prd   <= d_readM && !d_writeM;
            paddr <= d_address;
            if (d_writeM) begin
                wmem[d_address[7:0]]  <= d_data;
                wmask[d_address[7:0]] <= 1'b1;
                wr_log.push_back(d_address);
                wr_cyc.push_back(cyc);
            end else begin
                rd_log.push_back(d_address);
                rd_cyc.push_back(cyc);
            end
        end else begin
            if (busy != 2'd0) busy <= busy - 2'd1;
            drv <= (busy == 2'd1) && prd;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the request completes.
    task automatic read_op(input logic [15:0] a, output logic [15:0] data, output int lat);
        int t0;
        lat = -1;
        data = '0;
        cpu_readM = 1'b1;
        cpu_address = a;
        t0 = cyc;
        last_t0 = t0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cpu_ready) begin
                data = cpu_rdata;
                lat = cyc - t0;
                break;
            end
        end
        @(posedge clk);
        #1;
        cpu_readM = 1'b0;
    endtask

    task automatic write_op(input logic [15:0] a, input logic [15:0] d, output int lat,
                            output logic [15:0] bus);
        int t0;
        lat = -1;
        bus = '0;
        cpu_writeM = 1'b1;
        cpu_address = a;
        cpu_wdata = d;
        t0 = cyc;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cpu_ready) begin
                bus = d_data;
                lat = cyc - t0;
                break;
            end
        end
        @(posedge clk);
        #1;
        cpu_writeM = 1'b0;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic        exp_ready;
        logic        chk_data;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [15:0] data, bus;
        int lat, base, t_read1;

        // Line 0 holds {0x0000, 0x0001, 0xffff, 0x1234} when the table is applied.
        vecs[0] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};
        vecs[1] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 16'h0001, 1'b1, 1'b1, 16'h0001};
        vecs[3] = '{1'b1, 1'b0, 16'h0002, 1'b1, 1'b1, 16'hffff};
        vecs[4] = '{1'b1, 1'b0, 16'h0003, 1'b1, 1'b1, 16'h1234};
        vecs[5] = '{1'b1, 1'b0, 16'h0013, 1'b0, 1'b0, 16'h0000};
        vecs[6] = '{1'b1, 1'b0, 16'h0004, 1'b0, 1'b0, 16'h0000};
        vecs[7] = '{1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 16'h0000};
        vecs[8] = '{1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 16'h0000};
        vecs[9] = '{1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 16'h0000};

        // Reset state
        @(negedge clk);
        chk("reset cpu_ready", cpu_ready, 1);
        chk("reset d_readM", d_readM, 0);
        chk("reset d_writeM", d_writeM, 0);
        chk("reset d_address", d_address, 0);
        chk("reset hit_count", hit_count, 0);
        chk("reset miss_count", miss_count, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: cold read miss fills line 0
        base = rd_log.size();
        read_op(16'h0001, data, lat);
        t_read1 = last_t0;
        chk("t1 latency", lat, 14);
        chk("t1 rdata", data, 16'h0001);
        chk("t1 miss_count", miss_count, 1);
        chk("t1 hit_count", hit_count, 1);
        chk("t1 read count", rd_log.size() - base, 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t1 fill addr %0d", i), rd_log[base + i], (i == 4) ? 3 : i);
        end
        chk("t1 first accept cycle", rd_cyc[base] - t_read1, 1);
        chk("t1 word3 accept cycle", rd_cyc[base + 3] - t_read1, 10);
        chk("t1 trailing accept cycle", rd_cyc[base + 4] - t_read1, 13);

        // Test 3: write hit right after the fill waits out the trailing read
        write_op(16'h0003, 16'h1234, lat, bus);
        chk("t3 write latency", lat, 1);
        chk("t3 d_data", bus, 16'h1234);
        chk("t3 write count", wr_log.size(), 1);
        chk("t3 write addr", wr_log[0], 16'h0003);
        chk("t3 write accept cycle", wr_cyc[0] - t_read1, 16);
        read_op(16'h0003, data, lat);
        chk("t3 reread latency", lat, 0);
        chk("t3 reread rdata", data, 16'h1234);
        chk("t3 hit_count", hit_count, 2);

        // Test 2: read hit, no memory traffic
        base = rd_log.size();
        read_op(16'h0002, data, lat);
        chk("t2 latency", lat, 0);
        chk("t2 rdata", data, 16'hffff);
        chk("t2 no d_readM", rd_log.size() - base, 0);
        chk("t2 hit_count", hit_count, 3);

        // Combinational lookup table, inputs withdrawn before each edge
        for (int i = 0; i < 10; i++) begin
            cpu_readM = vecs[i].rd;
            cpu_writeM = vecs[i].wr;
            cpu_address = vecs[i].addr;
            cpu_wdata = 16'h5a5a;
            #2;
            chk($sformatf("vec%0d cpu_ready", i), cpu_ready, vecs[i].exp_ready);
            if (vecs[i].chk_data) chk($sformatf("vec%0d rdata", i), cpu_rdata, vecs[i].exp_data);
            chk($sformatf("vec%0d mem idle", i), {d_readM, d_writeM}, 0);
            cpu_readM = 1'b0;
            cpu_writeM = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("vec hit_count", hit_count, 3);

        // Test 4: write miss does not allocate
        write_op(16'h0011, 16'hbeef, lat, bus);
        chk("t4 write latency", lat, 1);
        chk("t4 write addr", wr_log[wr_log.size() - 1], 16'h0011);
        read_op(16'h0001, data, lat);
        chk("t4 line0 latency", lat, 0);
        chk("t4 line0 rdata", data, 16'h0001);
        base = rd_log.size();
        read_op(16'h0011, data, lat);
        chk("t4 miss latency", lat, 14);
        chk("t4 miss rdata", data, 16'hbeef);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4 fill addr %0d", i), rd_log[base + i], 16'h0010 + i);
        end
        read_op(16'h0001, data, lat);
        chk("t4 evicted latency", lat, 14);
        chk("t4 evicted rdata", data, 16'h0001);
        chk("t4 miss_count", miss_count, 3);
        chk("t4 hit_count", hit_count, 6);

        // Test 5: reset in cycle 8 of a fill
        cpu_readM = 1'b1;
        cpu_address = 16'h0001;
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t5 d_readM after reset", d_readM, 0);
        chk("t5 line invalid", cpu_ready, 0);
        chk("t5 hit_count", hit_count, 0);
        chk("t5 miss_count", miss_count, 0);
        cpu_readM = 1'b0;
        reset_n = 1'b1;
        base = rd_log.size();
        read_op(16'h0000, data, lat);
        chk("t5 refill rdata", data, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5 fill addr %0d", i), rd_log[base + i], i);
        end
        chk("t5 miss_count after", miss_count, 1);
        read_op(16'h0001, data, lat);
        chk("t5 hit latency", lat, 0);
        chk("t5 hit rdata", data, 16'h0001);
        chk("t5 hit_count after", hit_count, 2);

        // Test 6: hit counter saturation
        cpu_readM = 1'b1;
        cpu_address = 16'h0001;
        repeat (65532) @(posedge clk);
        @(negedge clk);
        chk("t6 hit_count fffe", hit_count, 16'hfffe);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("t6 hit_count sat", hit_count, 16'hffff);
        repeat (4000) @(posedge clk);
        @(negedge clk);
        chk("t6 hit_count held", hit_count, 16'hffff);
        chk("t6 miss_count", miss_count, 1);
        cpu_readM = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_dm.md
Name: dcache_dm

Overview:
Direct-mapped, write-through, no-write-allocate data cache between the CPU data port and the data interface of the Memory model. Read hits return in the request cycle. Read misses fill a whole line with sequential single-word reads over the 2-cycle memory. Writes go straight to memory and also update the cached word on a hit.

Parameters:
WORD_SIZE, 16, data and address width.
INDEX_BITS, 2, line-index width (4 lines).
OFFSET_BITS, 2, word-in-line width (4 words per line); tag width = WORD_SIZE-INDEX_BITS-OFFSET_BITS (12).

Ports:
clk  in  1  clock, all state on posedge.
reset_n  in  1  synchronous active-low reset.
cpu_readM  in  1  CPU read request; held constant while cpu_ready=0.
cpu_writeM  in  1  CPU write request; held constant while cpu_ready=0.
cpu_address  in  WORD_SIZE  word address.
cpu_wdata  in  WORD_SIZE  write data.
cpu_rdata  out  WORD_SIZE  read data, valid when cpu_readM && cpu_ready.
cpu_ready  out  1  request completes at the next posedge; 1 when idle with no request.
d_readM  out  1  memory read request.
d_writeM  out  1  memory write request.
d_address  out  WORD_SIZE  memory word address.
d_data  inout  WORD_SIZE  driven with write data only while d_writeM=1, else high-Z.
d_ready  in  1  memory idle; samples d_readM/d_writeM at a posedge while high.
hit_count  out  16  read hits since reset, saturating at 16'hffff.
miss_count  out  16  read misses since reset, saturating at 16'hffff.

Behaviour:
- Reset (reset_n=0 at posedge): all valid bits 0, state IDLE, d_readM=d_writeM=0, d_address=0, d_data high-Z, counters 0. cpu_ready=1 when there is no request. A reset during FILL or WRITE aborts the operation; the partial line stays invalid.
- Lookup: index=addr[OFFSET_BITS+:INDEX_BITS], offset=addr[OFFSET_BITS-1:0], tag=upper bits. Hit = valid[index] && tag match. Lookup is combinational.
- Memory protocol:
  - A request is accepted at a posedge with d_ready=1.
  - d_ready then stays low 2 cycles.
  - In the first cycle d_ready is high again, d_data carries read data, but only while d_readM=1.
- States: IDLE, FILL, WRITE.
- IDLE, read hit: cpu_ready=1 and cpu_rdata=line word in the same cycle; hit_count increments.
- IDLE, read miss: cpu_ready=0; miss_count increments; next state FILL with word counter w=0. Tag and valid are cleared.
- IDLE, write: cpu_ready=0; next state WRITE. Write has priority if cpu_readM and cpu_writeM are both asserted (illegal input).
- FILL:
  - Drive d_readM=1, d_address={tag,index,w}.
  - At the posedge when the word-w data is valid: store it, increment w, and keep d_readM=1 with the next address (memory accepts that read at the same edge).
  - After word 3 is stored: set valid and tag, go to IDLE, d_readM=0 from the next cycle. The request served by the miss then completes as a hit and increments hit_count as well.
  - The last capture edge necessarily starts one trailing read of word 3. Its data is ignored. Memory stays busy 2 more cycles, which delays only later memory operations.
- FILL timing, request first present in cycle 0, memory idle:
  - Read accepted at E1.
  - Words valid in cycles 4, 7, 10, 13.
  - cpu_ready=1 in cycle 14.
  - Next memory request accepted no earlier than cycle 16.
- WRITE:
  - Drive d_writeM=1, d_address=cpu_address, d_data=cpu_wdata.
  - cpu_ready = d_ready, combinationally, in this state.
  - At the accepting posedge: update the cached word if hit (valid and tag unchanged), return to IDLE, d_writeM=0 next cycle.
  - Latency with memory idle: 2 cycles (cpu_ready=1 in cycle 1).
- No memory request is ever issued while a previous one is outstanding. FILL and WRITE simply wait for d_ready=1.

Test Plan:
1. Reset, then read 0x0001 -> d_readM addresses 0x0000..0x0003 in order; cpu_ready=1 in cycle 14 with cpu_rdata=16'h0001; miss_count=1, hit_count=1.
2. After 1, read 0x0002 -> cpu_ready=1 same cycle, cpu_rdata=16'hffff, no d_readM; hit_count=2.
3. Write 0x0003 <- 16'h1234 right after 1 -> d_writeM waits until cycle 16 (trailing read), completes 1 cycle later; read 0x0003 then hits with 16'h1234.
4. Write 0x0011 <- 16'hbeef (index 0, tag 1, miss) -> memory written, line 0 unchanged; read 0x0001 still hits 16'h0001; read 0x0011 misses, fills 0x0010..0x0013, returns 16'hbeef.
5. reset_n=0 at cycle 8 of a fill -> d_readM=0 next cycle, all lines invalid; re-read 0x0001 -> full miss sequence again.
6. Run 70000 hits -> hit_count saturates at 16'hffff.
